// File: rtl/seq_pkg.sv
// Shared types and data-memory map for the job sequencer.
`timescale 1ns/1ps
package seq_pkg;

    typedef enum logic [1:0] {
        ProgIllegal = 2'd0,
        ProgRecip   = 2'd1,
        ProgDiv     = 2'd2,
        ProgSqrt    = 2'd3
    } prog_e;

    typedef enum logic [2:0] {
        StIdle, StLoad, StLaunch, StWait, StRead, StResp
    } state_e;

    localparam logic [7:0] AddrDivOpaHi  = 8'd0;
    localparam logic [7:0] AddrDivOpaLo  = 8'd1;
    localparam logic [7:0] AddrDivOpb    = 8'd2;
    localparam logic [7:0] AddrDivRes2   = 8'd4;
    localparam logic [7:0] AddrDivRes1   = 8'd5;
    localparam logic [7:0] AddrDivRes0   = 8'd6;
    localparam logic [7:0] AddrRcpOpaHi  = 8'd8;
    localparam logic [7:0] AddrRcpOpaLo  = 8'd9;
    localparam logic [7:0] AddrRcpResHi  = 8'd10;
    localparam logic [7:0] AddrRcpResLo  = 8'd11;
    localparam logic [7:0] AddrSqrtOpaHi = 8'd13;
    localparam logic [7:0] AddrSqrtOpaLo = 8'd14;
    localparam logic [7:0] AddrSqrtRes   = 8'd15;

    function automatic logic [1:0] load_len(prog_e p);
        logic [1:0] n;
        n = 2'd0;
        case (p)
            ProgRecip, ProgSqrt: n = 2'd2;
            ProgDiv:             n = 2'd3;
            default:             n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] read_len(prog_e p);
        logic [1:0] n;
        n = 2'd0;
        case (p)
            ProgRecip: n = 2'd2;
            ProgDiv:   n = 2'd3;
            ProgSqrt:  n = 2'd1;
            default:   n = 2'd0;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] load_addr(prog_e p, logic [1:0] i);
        logic [7:0] a;
        a = 8'd0;
        case (p)
            ProgRecip: a = i[0] ? AddrRcpOpaLo : AddrRcpOpaHi;
            ProgDiv:   a = (i == 2'd0) ? AddrDivOpaHi : (i == 2'd1) ? AddrDivOpaLo : AddrDivOpb;
            ProgSqrt:  a = i[0] ? AddrSqrtOpaLo : AddrSqrtOpaHi;
            default:   a = 8'd0;
        endcase
        return a;
    endfunction

    // Operand bytes go out big-endian; only the divide job carries OPB.
    function automatic logic [7:0] load_byte(logic [1:0] i, logic [15:0] opa, logic [7:0] opb);
        logic [7:0] d;
        d = 8'd0;
        case (i)
            2'd0:    d = opa[15:8];
            2'd1:    d = opa[7:0];
            default: d = opb;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] read_addr(prog_e p, logic [1:0] i);
        logic [7:0] a;
        a = 8'd0;
        case (p)
            ProgRecip: a = i[0] ? AddrRcpResLo : AddrRcpResHi;
            ProgDiv:   a = (i == 2'd0) ? AddrDivRes2 : (i == 2'd1) ? AddrDivRes1 : AddrDivRes0;
            ProgSqrt:  a = AddrSqrtRes;
            default:   a = 8'd0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Cycle counter for the WAIT state; expire marks the last permitted wait cycle.
`timescale 1ns/1ps
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [15:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expire = enable && (count_q == 16'(TIMEOUT - 1));

endmodule

// File: rtl/job_sequencer.sv
// Loads operands into core data memory, launches the core, collects the result.
// Optional SEQ_ZERO_TRAP_EN answers zero-operand jobs directly without running the core.
`timescale 1ns/1ps
module job_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic [1:0]  REQ_PROG,
    input  logic [15:0] REQ_OPA,
    input  logic [7:0]  REQ_OPB,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [1:0]  RSP_PROG,
    output logic [23:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        RSP_TIMEOUT,
    output logic        MEM_WE,
    output logic [7:0]  MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic [7:0]  MEM_RDATA,
    output logic        START,
    input  logic        DONE
);

    state_e      state_q;
    prog_e       prog_q;
    prog_e       req_prog;
    logic [15:0] opa_q;
    logic [7:0]  opb_q;
    logic [1:0]  idx_q;
    logic [3:0]  start_cnt_q;
    logic        expire;
    logic        trap;
    logic [23:0] trap_data;

    assign req_prog  = prog_e'(REQ_PROG);
    assign REQ_READY = (state_q == StIdle);

`ifdef SEQ_ZERO_TRAP_EN
    always_comb begin
        trap      = 1'b0;
        trap_data = '0;
        case (req_prog)
            ProgRecip: begin trap = (REQ_OPA == 16'd0); trap_data = 24'h00FFFF; end
            ProgDiv:   begin trap = (REQ_OPB == 8'd0);  trap_data = 24'hFFFFFF; end
            ProgSqrt:  begin trap = (REQ_OPA == 16'd0); trap_data = 24'h000000; end
            default:   begin trap = 1'b0;               trap_data = '0;          end
        endcase
    end
`else
    assign trap      = 1'b0;
    assign trap_data = '0;
`endif

    seq_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (CLK),
        .rst_n (RESET_N),
        .clear (state_q != StWait),
        .enable(state_q == StWait),
        .expire(expire)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            prog_q      <= ProgIllegal;
            opa_q       <= '0;
            opb_q       <= '0;
            idx_q       <= '0;
            start_cnt_q <= '0;
            START       <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
            RSP_VALID   <= 1'b0;
            RSP_DATA    <= '0;
            RSP_PROG    <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: if (REQ_VALID) begin
                    prog_q      <= req_prog;
                    opa_q       <= REQ_OPA;
                    opb_q       <= REQ_OPB;
                    RSP_PROG    <= REQ_PROG;
                    RSP_ERR     <= 1'b0;
                    RSP_TIMEOUT <= 1'b0;
                    RSP_DATA    <= '0;
                    if (req_prog == ProgIllegal) begin
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 1'b1;
                        state_q   <= StResp;
                    end else if (trap) begin
                        RSP_VALID <= 1'b1;
                        RSP_DATA  <= trap_data;
                        state_q   <= StResp;
                    end else begin
                        MEM_WE    <= 1'b1;
                        MEM_ADDR  <= load_addr(req_prog, 2'd0);
                        MEM_WDATA <= load_byte(2'd0, REQ_OPA, REQ_OPB);
                        idx_q     <= 2'd1;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    if (idx_q == load_len(prog_q)) begin
                        MEM_WE      <= 1'b0;
                        MEM_ADDR    <= '0;
                        MEM_WDATA   <= '0;
                        START       <= 1'b1;
                        start_cnt_q <= 4'd1;
                        state_q     <= StLaunch;
                    end else begin
                        MEM_ADDR  <= load_addr(prog_q, idx_q);
                        MEM_WDATA <= load_byte(idx_q, opa_q, opb_q);
                        idx_q     <= idx_q + 2'd1;
                    end
                end
                StLaunch: begin
                    if (start_cnt_q == 4'(START_CYCLES)) begin
                        START       <= 1'b0;
                        start_cnt_q <= '0;
                        state_q     <= StWait;
                    end else begin
                        start_cnt_q <= start_cnt_q + 4'd1;
                    end
                end
                StWait: begin
                    // DONE takes priority over a simultaneous expiry.
                    if (DONE) begin
                        MEM_ADDR <= read_addr(prog_q, 2'd0);
                        idx_q    <= 2'd1;
                        RSP_DATA <= '0;
                        state_q  <= StRead;
                    end else if (expire) begin
                        RSP_VALID   <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_DATA    <= 24'hFFFFFF;
                        state_q     <= StResp;
                    end
                end
                StRead: begin
                    RSP_DATA <= {RSP_DATA[15:0], MEM_RDATA};
                    if (idx_q == read_len(prog_q)) begin
                        MEM_ADDR  <= '0;
                        RSP_VALID <= 1'b1;
                        state_q   <= StResp;
                    end else begin
                        MEM_ADDR <= read_addr(prog_q, idx_q);
                        idx_q    <= idx_q + 2'd1;
                    end
                end
                StResp: begin
                    // One dead cycle after the handshake keeps REQ_READY off the RSP_VALID edge.
                    if (RSP_VALID) begin
                        if (RSP_READY) RSP_VALID <= 1'b0;
                    end else begin
                        idx_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_job_sequencer.sv
// Directed, table-driven bench for job_sequencer with a stub core and byte memory.
`timescale 1ns/1ps
module tb_job_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [1:0]  REQ_PROG = '0;
    logic [15:0] REQ_OPA = '0;
    logic [7:0]  REQ_OPB = '0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [1:0]  RSP_PROG;
    logic [23:0] RSP_DATA;
    logic        RSP_ERR;
    logic        RSP_TIMEOUT;
    logic        MEM_WE;
    logic [7:0]  MEM_ADDR;
    logic [7:0]  MEM_WDATA;
    logic [7:0]  MEM_RDATA;
    logic        START;
    logic        DONE = 1'b0;

    logic        core_we = 1'b0;
    logic [7:0]  core_addr = '0;
    logic [7:0]  core_wdata = '0;
    logic [7:0]  mem [256];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        else if (core_we) mem[core_addr] <= core_wdata;
    end
    assign MEM_RDATA = mem[MEM_ADDR];

    job_sequencer #(
        .START_CYCLES(2),
        .TIMEOUT     (100)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_PROG   (REQ_PROG),
        .REQ_OPA    (REQ_OPA),
        .REQ_OPB    (REQ_OPB),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_PROG   (RSP_PROG),
        .RSP_DATA   (RSP_DATA),
        .RSP_ERR    (RSP_ERR),
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .START      (START),
        .DONE       (DONE)
    );

    typedef struct {
        logic [1:0]  prog;
        logic [15:0] opa;
        logic [7:0]  opb;
        logic [23:0] res;      // value the stub core leaves in memory
        bit          core_ok;  // stub core answers with DONE
        bit          launch;   // job is expected to reach the core
        logic [23:0] exp_data;
        bit          exp_err;
        bit          exp_to;
        int          hold;     // cycles RSP_READY stays low
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [7:0] wa[3];
        logic [7:0] wd[3];
        logic [7:0] ra[3];
        logic [7:0] rd[3];
        int en, rn, wn, starts, first_start, waitn, wc;
        bit got;
        logic [23:0] held;
        en = 0; rn = 0; wn = 0; starts = 0; first_start = -1; waitn = 0; wc = 0; got = 0;
        wa = '{8'd0, 8'd0, 8'd0}; wd = '{8'd0, 8'd0, 8'd0};
        ra = '{8'd0, 8'd0, 8'd0}; rd = '{8'd0, 8'd0, 8'd0};
        case (v.prog)
            2'd1: begin
                en = 2; wa = '{8'd8, 8'd9, 8'd0};  wd = '{v.opa[15:8], v.opa[7:0], 8'd0};
                rn = 2; ra = '{8'd10, 8'd11, 8'd0}; rd = '{v.res[15:8], v.res[7:0], 8'd0};
            end
            2'd2: begin
                en = 3; wa = '{8'd0, 8'd1, 8'd2};  wd = '{v.opa[15:8], v.opa[7:0], v.opb};
                rn = 3; ra = '{8'd4, 8'd5, 8'd6};   rd = '{v.res[23:16], v.res[15:8], v.res[7:0]};
            end
            2'd3: begin
                en = 2; wa = '{8'd13, 8'd14, 8'd0}; wd = '{v.opa[15:8], v.opa[7:0], 8'd0};
                rn = 1; ra = '{8'd15, 8'd0, 8'd0};  rd = '{v.res[7:0], 8'd0, 8'd0};
            end
            default: ;
        endcase

        @(negedge CLK);
        chk($sformatf("v%0d req_ready", id), REQ_READY, 1);
        REQ_VALID = 1'b1; REQ_PROG = v.prog; REQ_OPA = v.opa; REQ_OPB = v.opb;
        @(negedge CLK);
        REQ_VALID = 1'b0;

        for (int cyc = 0; cyc < 400 && !got; cyc++) begin
            if (RSP_VALID) begin
                got = 1;
            end else begin
                if (MEM_WE) begin
                    if (wn < 3) begin
                        chk($sformatf("v%0d waddr%0d", id, wn), MEM_ADDR, wa[wn]);
                        chk($sformatf("v%0d wdata%0d", id, wn), MEM_WDATA, wd[wn]);
                    end
                    wn++;
                end
                core_we = 1'b0;
                DONE    = 1'b0;
                if (START) begin
                    if (first_start < 0) first_start = cyc;
                    starts++;
                end else if (starts > 0) begin
                    waitn++;
                    if (v.core_ok) begin
                        wc++;
                        if (wc <= rn) begin
                            core_we = 1'b1; core_addr = ra[wc-1]; core_wdata = rd[wc-1];
                        end
                        if (wc == 5) DONE = 1'b1;
                    end
                end
                @(negedge CLK);
            end
        end
        core_we = 1'b0;
        DONE    = 1'b0;

        chk($sformatf("v%0d rsp_seen", id), got, 1);
        chk($sformatf("v%0d rsp_data", id), RSP_DATA, v.exp_data);
        chk($sformatf("v%0d rsp_err", id), RSP_ERR, v.exp_err);
        chk($sformatf("v%0d rsp_timeout", id), RSP_TIMEOUT, v.exp_to);
        chk($sformatf("v%0d rsp_prog", id), RSP_PROG, v.prog);
        chk($sformatf("v%0d start_cycles", id), starts, v.launch ? 2 : 0);
        chk($sformatf("v%0d write_count", id), wn, v.launch ? en : 0);
        if (v.launch) chk($sformatf("v%0d start_latency", id), first_start, en);
        if (v.launch && !v.core_ok) chk($sformatf("v%0d wait_cycles", id), waitn, 100);

        held = RSP_DATA;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge CLK);
            chk($sformatf("v%0d hold%0d valid", id, h), RSP_VALID, 1);
            chk($sformatf("v%0d hold%0d data", id, h), RSP_DATA, held);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        RSP_READY = 1'b0;
        chk($sformatf("v%0d valid_drop", id), RSP_VALID, 0);
        chk($sformatf("v%0d ready_gap", id), REQ_READY, 0);
        @(negedge CLK);
        chk($sformatf("v%0d ready_back", id), REQ_READY, 1);
    endtask

    initial begin
        int starts;
        vecs[0] = '{2'd1, 16'h0003, 8'h00, 24'h005555, 1, 1, 24'h005555, 0, 0, 0};
        vecs[1] = '{2'd2, 16'h0001, 8'h03, 24'h005555, 1, 1, 24'h005555, 0, 0, 5};
        vecs[2] = '{2'd3, 16'hFFFF, 8'h00, 24'h000000, 0, 1, 24'hFFFFFF, 0, 1, 0};
        vecs[3] = '{2'd0, 16'h1234, 8'h56, 24'h000000, 0, 0, 24'h000000, 1, 0, 2};
        vecs[4] = '{2'd2, 16'hABCD, 8'h12, 24'h123456, 1, 1, 24'h123456, 0, 0, 0};
        vecs[5] = '{2'd3, 16'h0010, 8'h00, 24'hABCD04, 1, 1, 24'h000004, 0, 0, 0};
        vecs[7] = '{2'd1, 16'h1234, 8'h00, 24'hEEFF12, 1, 1, 24'h00FF12, 0, 0, 0};
`ifdef SEQ_ZERO_TRAP_EN
        vecs[6] = '{2'd1, 16'h0000, 8'h00, 24'h00ABCD, 1, 0, 24'h00FFFF, 0, 0, 0};
        vecs[8] = '{2'd2, 16'h0100, 8'h00, 24'h00FFFF, 1, 0, 24'hFFFFFF, 0, 0, 0};
        vecs[9] = '{2'd3, 16'h0000, 8'h00, 24'h000009, 1, 0, 24'h000000, 0, 0, 0};
`else
        vecs[6] = '{2'd1, 16'h0000, 8'h00, 24'h00ABCD, 1, 1, 24'h00ABCD, 0, 0, 0};
        vecs[8] = '{2'd2, 16'h0100, 8'h00, 24'h00FFFF, 1, 1, 24'h00FFFF, 0, 0, 0};
        vecs[9] = '{2'd3, 16'h0000, 8'h00, 24'h000009, 1, 1, 24'h000009, 0, 0, 0};
`endif

        repeat (2) @(negedge CLK);
        chk("reset outs_a", {START, MEM_WE, MEM_ADDR, MEM_WDATA, RSP_VALID}, 0);
        chk("reset outs_b", {RSP_DATA, RSP_PROG, RSP_ERR, RSP_TIMEOUT}, 0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("reset first_ready", REQ_READY, 1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset pulse while the core is busy: the job must vanish without a response.
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_PROG = 2'd2; REQ_OPA = 16'h0001; REQ_OPB = 8'h03;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        starts = 0;
        for (int c = 0; c < 20 && !(starts > 0 && !START); c++) begin
            if (START) starts++;
            @(negedge CLK);
        end
        chk("midwait reached", starts, 2);
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("midwait outs_a", {START, MEM_WE, MEM_ADDR, MEM_WDATA, RSP_VALID}, 0);
        chk("midwait outs_b", {RSP_DATA, RSP_PROG, RSP_ERR, RSP_TIMEOUT}, 0);
        chk("midwait ready", REQ_READY, 1);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk($sformatf("midwait no_rsp%0d", c), RSP_VALID, 0);
        end
        run_vec(vecs[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
